// File: rtl/core.sv
`default_nettype none
// ============================================================================
//  Module   : core
//  Purpose  : Single-cycle RV32I-subset core. Fetch comes from a flat 32-word
//             ROM bus. Optional MUL is enabled by defining CORE_RV32M_MUL_EN.
//  Revision : 1.0  initial release
// ============================================================================
module core #(
    parameter int DMEM_WORDS = 64,
    parameter int OUT_REG    = 6
) (
    input  logic [1023:0] i_memory_input,
    input  logic          clk,
    input  logic          rst,
    output logic [31:0]   output_register
);

    localparam int DMEM_AW = $clog2(DMEM_WORDS);

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] F7_BASE    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;
`ifdef CORE_RV32M_MUL_EN
    localparam logic [6:0] F7_MULDIV  = 7'b0000001;
`endif

    logic [6:0]         pc;
    logic [6:0]         pc_next;
    logic [31:0]        regs [32];
    logic [31:0]        dmem [DMEM_WORDS];

    logic [31:0]        instr;
    logic [6:0]         opcode;
    logic [4:0]         rd;
    logic [4:0]         rs1;
    logic [4:0]         rs2;
    logic [2:0]         funct3;
    logic [6:0]         funct7;

    logic [31:0]        rs1_val;
    logic [31:0]        rs2_val;
    logic [31:0]        imm_i;
    logic [31:0]        imm_s;
    logic [31:0]        imm_b;
    logic [31:0]        imm_j;
    logic [31:0]        imm_u;
    logic [31:0]        link;
    logic [31:0]        jalr_sum;
    logic [31:0]        mem_addr;
    logic [DMEM_AW-1:0] mem_idx;
    logic [31:0]        mem_rdata;

    logic               rd_we;
    logic [31:0]        rd_data;
    logic               mem_we;
    logic               branch_taken;

    assign instr  = i_memory_input[{pc[6:2], 5'b00000} +: 32];
    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign funct3 = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign funct7 = instr[31:25];

    assign rs1_val = (rs1 == 5'd0) ? 32'd0 : regs[rs1];
    assign rs2_val = (rs2 == 5'd0) ? 32'd0 : regs[rs2];

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    assign imm_u = {instr[31:12], 12'd0};

    // Link value is the unwrapped byte address of the next instruction.
    assign link     = {25'd0, pc} + 32'd4;
    assign jalr_sum = rs1_val + imm_i;
    assign mem_addr = rs1_val + ((opcode == OPC_STORE) ? imm_s : imm_i);
    assign mem_idx  = mem_addr[DMEM_AW+1:2];
    assign mem_rdata = dmem[mem_idx];

    // Address bits above the memory/pc window are intentionally discarded.
    logic unused_bits;
    assign unused_bits = ^{imm_b[31:7], imm_j[31:7], jalr_sum[31:7], jalr_sum[0],
                           mem_addr[31:DMEM_AW+2], mem_addr[1:0]};

`ifdef CORE_RV32M_MUL_EN
    logic [31:0] mul_lo;
    assign mul_lo = rs1_val * rs2_val;
`endif

    always_comb begin
        pc_next      = pc + 7'd4;
        rd_we        = 1'b0;
        rd_data      = 32'd0;
        mem_we       = 1'b0;
        branch_taken = 1'b0;
        case (opcode)
            OPC_OP_IMM: begin
                case (funct3)
                    3'b000: begin rd_we = 1'b1; rd_data = rs1_val + imm_i; end
                    3'b010: begin rd_we = 1'b1; rd_data = {31'd0, $signed(rs1_val) < $signed(imm_i)}; end
                    3'b011: begin rd_we = 1'b1; rd_data = {31'd0, rs1_val < imm_i}; end
                    3'b100: begin rd_we = 1'b1; rd_data = rs1_val ^ imm_i; end
                    3'b110: begin rd_we = 1'b1; rd_data = rs1_val | imm_i; end
                    3'b111: begin rd_we = 1'b1; rd_data = rs1_val & imm_i; end
                    3'b001: begin
                        if (funct7 == F7_BASE) begin
                            rd_we   = 1'b1;
                            rd_data = rs1_val << rs2;
                        end
                    end
                    3'b101: begin
                        if (funct7 == F7_BASE) begin
                            rd_we   = 1'b1;
                            rd_data = rs1_val >> rs2;
                        end else if (funct7 == F7_ALT) begin
                            rd_we   = 1'b1;
                            rd_data = $signed(rs1_val) >>> rs2;
                        end
                    end
                    default: ;
                endcase
            end
            OPC_OP: begin
                if (funct7 == F7_BASE) begin
                    rd_we = 1'b1;
                    case (funct3)
                        3'b000:  rd_data = rs1_val + rs2_val;
                        3'b001:  rd_data = rs1_val << rs2_val[4:0];
                        3'b010:  rd_data = {31'd0, $signed(rs1_val) < $signed(rs2_val)};
                        3'b011:  rd_data = {31'd0, rs1_val < rs2_val};
                        3'b100:  rd_data = rs1_val ^ rs2_val;
                        3'b101:  rd_data = rs1_val >> rs2_val[4:0];
                        3'b110:  rd_data = rs1_val | rs2_val;
                        default: rd_data = rs1_val & rs2_val;
                    endcase
                end else if (funct7 == F7_ALT) begin
                    if (funct3 == 3'b000) begin
                        rd_we   = 1'b1;
                        rd_data = rs1_val - rs2_val;
                    end else if (funct3 == 3'b101) begin
                        rd_we   = 1'b1;
                        rd_data = $signed(rs1_val) >>> rs2_val[4:0];
                    end
                end
`ifdef CORE_RV32M_MUL_EN
                else if ((funct7 == F7_MULDIV) && (funct3 == 3'b000)) begin
                    rd_we   = 1'b1;
                    rd_data = mul_lo;
                end
`endif
            end
            OPC_LUI: begin
                rd_we   = 1'b1;
                rd_data = imm_u;
            end
            OPC_LOAD: begin
                if (funct3 == 3'b010) begin
                    rd_we   = 1'b1;
                    rd_data = mem_rdata;
                end
            end
            OPC_STORE: begin
                if (funct3 == 3'b010) mem_we = 1'b1;
            end
            OPC_BRANCH: begin
                case (funct3)
                    3'b000:  branch_taken = (rs1_val == rs2_val);
                    3'b001:  branch_taken = (rs1_val != rs2_val);
                    3'b100:  branch_taken = ($signed(rs1_val) <  $signed(rs2_val));
                    3'b101:  branch_taken = ($signed(rs1_val) >= $signed(rs2_val));
                    3'b110:  branch_taken = (rs1_val <  rs2_val);
                    3'b111:  branch_taken = (rs1_val >= rs2_val);
                    default: branch_taken = 1'b0;
                endcase
                if (branch_taken) pc_next = pc + imm_b[6:0];
            end
            OPC_JAL: begin
                rd_we   = 1'b1;
                rd_data = link;
                pc_next = pc + imm_j[6:0];
            end
            OPC_JALR: begin
                if (funct3 == 3'b000) begin
                    rd_we   = 1'b1;
                    rd_data = link;
                    pc_next = {jalr_sum[6:1], 1'b0};
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= 7'd0;
            for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
        end else begin
            pc <= pc_next;
            if (rd_we && (rd != 5'd0)) regs[rd] <= rd_data;
        end
    end

    // Data memory survives reset; stores are suppressed while reset is held.
    always_ff @(posedge clk) begin
        if (mem_we && !rst) dmem[mem_idx] <= rs2_val;
    end

    assign output_register = regs[OUT_REG];

endmodule
`default_nettype wire

// File: tb/tb_core.sv
`default_nettype none
// Bench for core: directed programs plus random instruction streams, each
// cycle compared against an instruction-level reference model.
module tb_core;
    localparam int DMEM_WORDS = 64;
    localparam int OUT_REG    = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic [1023:0] image;
    logic [31:0]   out_reg;

    core #(.DMEM_WORDS(DMEM_WORDS), .OUT_REG(OUT_REG)) dut (
        .i_memory_input (image),
        .clk            (clk),
        .rst            (rst),
        .output_register(out_reg)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [31:0] prog  [32];
    logic [31:0] m_x   [32];
    logic [31:0] m_mem [DMEM_WORDS];
    logic [31:0] m_pc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc_i(int imm, int rs1, int f3, int rd, int op);
        logic [31:0] im = imm;
        return {im[11:0], 5'(rs1), 3'(f3), 5'(rd), 7'(op)};
    endfunction
    function automatic logic [31:0] enc_s(int imm, int rs2, int rs1);
        logic [31:0] im = imm;
        return {im[11:5], 5'(rs2), 5'(rs1), 3'b010, im[4:0], 7'h23};
    endfunction
    function automatic logic [31:0] enc_b(int imm, int rs2, int rs1, int f3);
        logic [31:0] im = imm;
        return {im[12], im[10:5], 5'(rs2), 5'(rs1), 3'(f3), im[4:1], im[11], 7'h63};
    endfunction
    function automatic logic [31:0] enc_j(int imm, int rd);
        logic [31:0] im = imm;
        return {im[20], im[10:1], im[11], im[19:12], 5'(rd), 7'h6f};
    endfunction
    function automatic logic [31:0] addi(int rd, int rs1, int imm); return enc_i(imm, rs1, 0, rd, 'h13); endfunction
    function automatic logic [31:0] lw(int rd, int rs1, int imm);   return enc_i(imm, rs1, 2, rd, 'h03); endfunction
    function automatic logic [31:0] sw(int rs2, int rs1, int imm);  return enc_s(imm, rs2, rs1); endfunction
    function automatic logic [31:0] beq(int rs1, int rs2, int off); return enc_b(off, rs2, rs1, 0); endfunction
    function automatic logic [31:0] bne(int rs1, int rs2, int off); return enc_b(off, rs2, rs1, 1); endfunction
    function automatic logic [31:0] rtype(int f7, int rd, int rs1, int rs2, int f3);
        return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'h33};
    endfunction

    function automatic logic [6:0] pick_f7();
        case ($urandom_range(0, 3))
            0:       return 7'h00;
            1:       return 7'h20;
            2:       return 7'h01;
            default: return 7'($urandom);
        endcase
    endfunction

    function automatic logic [31:0] rand_instr();
        int rd  = $urandom_range(0, 7);
        int rs1 = $urandom_range(0, 7);
        int rs2 = $urandom_range(0, 7);
        int f3  = $urandom_range(0, 7);
        int imm = $urandom_range(0, 4095) - 2048;
        int off = $urandom_range(0, 32) * 4 - 64 + (($urandom_range(0, 3) == 0) ? 2 : 0);
        case ($urandom_range(0, 10))
            0, 1: begin
                if (f3 == 1 || f3 == 5)
                    return {pick_f7(), 5'($urandom), 5'(rs1), 3'(f3), 5'(rd), 7'h13};
                return enc_i(imm, rs1, f3, rd, 'h13);
            end
            2, 3: return rtype(pick_f7(), rd, rs1, rs2, f3);
            4:    return {20'($urandom), 5'(rd), 7'h37};
            5:    return enc_i(imm, rs1, ($urandom_range(0, 3) == 0) ? f3 : 2, rd, 'h03);
            6:    return ($urandom_range(0, 3) == 0) ? {enc_s(imm, rs2, rs1) ^ 32'h0000_3000}
                                                     : enc_s(imm, rs2, rs1);
            7, 8: return enc_b(off, rs2, rs1, f3);
            9:    return ($urandom_range(0, 1) == 0) ? enc_j(off, rd)
                                                     : enc_i(imm, rs1, ($urandom_range(0, 3) == 0) ? f3 : 0, rd, 'h67);
            default: return $urandom;
        endcase
    endfunction

    // Reference ISA model: one instruction per call.
    task automatic model_step();
        logic [31:0] ins, a, b, val, imm_i, imm_s, imm_b, imm_j, nxt;
        logic [6:0]  op, f7;
        logic [2:0]  f3;
        logic [4:0]  rd, rs1, rs2;
        bit          wr, tk;
        ins = prog[m_pc[6:2]];
        op = ins[6:0]; rd = ins[11:7]; f3 = ins[14:12];
        rs1 = ins[19:15]; rs2 = ins[24:20]; f7 = ins[31:25];
        a = m_x[rs1]; b = m_x[rs2];
        imm_i = {{20{ins[31]}}, ins[31:20]};
        imm_s = {{20{ins[31]}}, ins[31:25], ins[11:7]};
        imm_b = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        imm_j = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        nxt = m_pc + 4; wr = 0; val = 0; tk = 0;
        case (op)
            7'h13: begin
                wr = 1;
                case (f3)
                    0: val = a + imm_i;
                    2: val = ($signed(a) < $signed(imm_i)) ? 1 : 0;
                    3: val = (a < imm_i) ? 1 : 0;
                    4: val = a ^ imm_i;
                    6: val = a | imm_i;
                    7: val = a & imm_i;
                    1: if (f7 == 0) val = a << rs2; else wr = 0;
                    default: if (f7 == 0) val = a >> rs2;
                             else if (f7 == 7'h20) val = $signed(a) >>> rs2;
                             else wr = 0;
                endcase
            end
            7'h33: begin
                wr = 1;
                if (f7 == 0) begin
                    case (f3)
                        0: val = a + b;
                        1: val = a << b[4:0];
                        2: val = ($signed(a) < $signed(b)) ? 1 : 0;
                        3: val = (a < b) ? 1 : 0;
                        4: val = a ^ b;
                        5: val = a >> b[4:0];
                        6: val = a | b;
                        default: val = a & b;
                    endcase
                end else if (f7 == 7'h20 && f3 == 0) val = a - b;
                else if (f7 == 7'h20 && f3 == 5) val = $signed(a) >>> b[4:0];
`ifdef CORE_RV32M_MUL_EN
                else if (f7 == 7'h01 && f3 == 0) val = a * b;
`endif
                else wr = 0;
            end
            7'h37: begin wr = 1; val = {ins[31:12], 12'd0}; end
            7'h03: if (f3 == 2) begin wr = 1; val = m_mem[((a + imm_i) >> 2) % DMEM_WORDS]; end
            7'h23: if (f3 == 2) m_mem[((a + imm_s) >> 2) % DMEM_WORDS] = b;
            7'h63: begin
                case (f3)
                    0: tk = (a == b);
                    1: tk = (a != b);
                    4: tk = ($signed(a) < $signed(b));
                    5: tk = ($signed(a) >= $signed(b));
                    6: tk = (a < b);
                    7: tk = (a >= b);
                    default: tk = 0;
                endcase
                if (tk) nxt = m_pc + imm_b;
            end
            7'h6f: begin wr = 1; val = m_pc + 4; nxt = m_pc + imm_j; end
            7'h67: if (f3 == 0) begin wr = 1; val = m_pc + 4; nxt = (a + imm_i) & ~32'd1; end
            default: ;
        endcase
        if (wr && rd != 0) m_x[rd] = val;
        m_pc = nxt % 128;
    endtask

    task automatic load_and_reset();
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 32; i++) image[i*32 +: 32] = prog[i];
        m_pc = 0;
        for (int i = 0; i < 32; i++) m_x[i] = 0;
        #1;
        check("async_rst_pc", {25'd0, dut.pc}, 32'd0);
        repeat (2) begin
            @(posedge clk); #1;
            check("rst_pc", {25'd0, dut.pc}, 32'd0);
            check("rst_out", out_reg, 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_step();
        #1;
        check({tag, "_pc"}, {25'd0, dut.pc}, m_pc);
        check({tag, "_out"}, out_reg, m_x[OUT_REG]);
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 32; i++) prog[i] = 32'd0;
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < 32; i++) check(tag, dut.regs[i], m_x[i]);
    endtask

    initial begin
        int fibv [10] = '{1, 1, 2, 3, 5, 8, 13, 21, 34, 55};
        rst   = 1'b1;
        image = '0;
        for (int i = 0; i < DMEM_WORDS; i++) m_mem[i] = 0;

        // Reset with a random image, then Fibonacci.
        for (int i = 0; i < 32; i++) prog[i] = $urandom;
        load_and_reset();
        clear_prog();
        prog[0]  = addi(1, 0, 1);   prog[1]  = addi(2, 0, 1);
        prog[2]  = sw(1, 0, 0);     prog[3]  = sw(2, 0, 4);
        prog[4]  = addi(7, 0, 4);   prog[5]  = addi(4, 0, 2);
        prog[6]  = addi(5, 0, 10);  prog[7]  = addi(0, 0, 0);
        prog[8]  = rtype(0, 3, 1, 2, 0);
        prog[9]  = addi(7, 7, 4);   prog[10] = sw(3, 7, 0);
        prog[11] = addi(1, 2, 0);   prog[12] = addi(2, 3, 0);
        prog[13] = addi(4, 4, 1);   prog[14] = beq(4, 5, 8);
        prog[15] = beq(0, 0, -28);  prog[16] = lw(6, 7, 0);
        prog[17] = addi(4, 4, 1);   prog[18] = beq(0, 0, -4);
        load_and_reset();
        for (int c = 1; c <= 72; c++) begin
            step("fib");
            if (c == 15) check("beq_not_taken_pc", {25'd0, dut.pc}, 32'd60);
            if (c == 16) check("beq_back_pc", {25'd0, dut.pc}, 32'd32);
        end
        check("fib_out", out_reg, 32'd55);
        check("fib_x7", dut.regs[7], 32'd36);
        for (int i = 0; i < 10; i++) check("fib_dmem", dut.dmem[i], fibv[i]);
        for (int c = 0; c < 10; c++) step("spin");
        check("spin_x4", dut.regs[4], 32'd15);
        check("spin_out", out_reg, 32'd55);

        // Immediate sign, x0 discard, arithmetic shift.
        clear_prog();
        prog[0] = addi(1, 0, -1); prog[1] = addi(0, 0, 5);
        prog[2] = {7'h20, 5'd4, 5'd1, 3'b101, 5'd2, 7'h13};
        load_and_reset();
        repeat (3) step("imm");
        check("addi_neg", dut.regs[1], 32'hFFFF_FFFF);
        check("x0_zero", dut.regs[0], 32'd0);
        check("srai", dut.regs[2], 32'hFFFF_FFFF);

        // Taken bne with +8.
        clear_prog();
        prog[0] = addi(1, 0, 1); prog[1] = bne(1, 0, 8);
        load_and_reset();
        repeat (2) step("bne");
        check("bne_taken_pc", {25'd0, dut.pc}, 32'd12);

        // All-zero image: NOP stream with wrap.
        clear_prog();
        load_and_reset();
        for (int k = 1; k <= 33; k++) begin
            step("nop");
            if (k % 8 == 0 || k == 32 || k == 33)
                check("nop_wrap_pc", {25'd0, dut.pc}, (4 * k) % 128);
        end
        check_regs("nop_regs");

        // Store to DMEM_WORDS*4 aliases word 0.
        clear_prog();
        prog[0] = addi(1, 0, 'h5a); prog[1] = addi(2, 0, DMEM_WORDS * 4);
        prog[2] = sw(1, 2, 0);      prog[3] = lw(6, 0, 0);
        load_and_reset();
        repeat (4) step("alias");
        check("alias_out", out_reg, 32'h5a);

        // MUL encoding, enabled or NOP depending on build.
        clear_prog();
        prog[0] = addi(1, 0, 7); prog[1] = addi(2, 0, -3);
        prog[2] = addi(6, 0, 5); prog[3] = rtype(1, 6, 1, 2, 0);
        load_and_reset();
        repeat (4) step("mul");
`ifdef CORE_RV32M_MUL_EN
        check("mul_out", out_reg, 32'hFFFF_FFEB);
`else
        check("mul_out", out_reg, 32'd5);
`endif

        // Zero the data memory so random loads have defined contents.
        clear_prog();
        prog[0] = addi(1, 0, 0); prog[1] = addi(2, 0, DMEM_WORDS * 4);
        prog[2] = sw(0, 1, 0);   prog[3] = addi(1, 1, 4);
        prog[4] = bne(1, 2, -8); prog[5] = beq(0, 0, 0);
        load_and_reset();
        repeat (DMEM_WORDS * 3 + 6) step("clr");

        // Random instruction streams.
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < 32; i++) prog[i] = rand_instr();
            load_and_reset();
            repeat (64) step("rand");
            check_regs("rand_regs");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
